// File: rtl/input_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : input_sweep_checker
// Description : Exhaustive input sweeper for combinational lab DUTs; samples
//               each response after a dwell and folds it into a MISR.
// Revision    : 1.0 - initial release
// ============================================================================
module input_sweep_checker #(
    parameter int              IN_W  = 3,
    parameter int              OUT_W = 5,
    parameter int              DWELL = 100,
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             stepReq,
    output logic [IN_W-1:0]  vecOut,
    input  logic [OUT_W-1:0] dutIn,
    output logic             sampleValid,
    output logic [IN_W-1:0]  sampleVec,
    output logic [OUT_W-1:0] sampleData,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sigOut
);

    localparam int CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] MODE_CONT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [IN_W-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIG_W-1:0] acc_q, acc_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             sv_q, sv_d;
    logic [IN_W-1:0]  svec_q, svec_d;
    logic [OUT_W-1:0] sdata_q, sdata_d;
    logic             done_q, done_d;

    logic [SIG_W-1:0] w_ext;
    logic [SIG_W-1:0] w_fold;

    always_comb begin
        w_ext = '0;
        w_ext[OUT_W-1:0] = dutIn;
    end

    // Shift-left MISR step with the current response folded in.
    assign w_fold = {acc_q[SIG_W-2:0], 1'b0} ^ (acc_q[SIG_W-1] ? POLY : '0) ^ w_ext;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sig_d   = sig_q;
        sv_d    = 1'b0;
        svec_d  = svec_q;
        sdata_d = sdata_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            vec_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_DRIVE;
                        mode_d  = mode;
                        vec_d   = '0;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        sv_d    = 1'b1;
                        svec_d  = vec_q;
                        sdata_d = dutIn;
                        acc_d   = w_fold;
                        cnt_d   = '0;
                        if (&vec_q) begin
                            sig_d  = w_fold;
                            done_d = 1'b1;
                            vec_d  = '0;
                            if (mode_q == MODE_CONT) begin
                                acc_d = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else if (mode_q == MODE_STEP) begin
                            state_d = ST_WAIT;
                        end else begin
                            vec_d = vec_q + IN_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (stepReq) begin
                        state_d = ST_DRIVE;
                        vec_d   = vec_q + IN_W'(1);
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sig_q   <= '0;
            sv_q    <= 1'b0;
            svec_q  <= '0;
            sdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sig_q   <= sig_d;
            sv_q    <= sv_d;
            svec_q  <= svec_d;
            sdata_q <= sdata_d;
            done_q  <= done_d;
        end
    end

    assign vecOut      = vec_q;
    assign sampleValid = sv_q;
    assign sampleVec   = svec_q;
    assign sampleData  = sdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign sigOut      = sig_q;

endmodule
`default_nettype wire

// File: tb/tb_input_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_sweep_checker
// Description : Directed, table-driven bench for input_sweep_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_sweep_checker;

    localparam int C_DWELL = 4;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        stepReq = 1'b0;
    logic [2:0]  vecOut;
    logic [4:0]  dutIn;
    logic        sampleValid;
    logic [2:0]  sampleVec;
    logic [4:0]  sampleData;
    logic        busy;
    logic        done;
    logic [15:0] sigOut;

    int checks = 0;
    int errors = 0;
    int pat = 0;

    input_sweep_checker #(
        .IN_W (3),
        .OUT_W(5),
        .DWELL(C_DWELL),
        .SIG_W(16),
        .POLY (16'h1021)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .stepReq    (stepReq),
        .vecOut     (vecOut),
        .dutIn      (dutIn),
        .sampleValid(sampleValid),
        .sampleVec  (sampleVec),
        .sampleData (sampleData),
        .busy       (busy),
        .done       (done),
        .sigOut     (sigOut)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] pat_val(int p, logic [2:0] v);
        case (p)
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return {2'b00, v};
            default: return {2'b10, v};
        endcase
    endfunction

    // Combinational lab DUT stand-in
    always_comb dutIn = pat_val(pat, vecOut);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of a gap-free sweep; k counts cycles since the start edge
    task automatic chk_flow(int k, int p, bit cont);
        int kk;
        kk = cont ? (k % 32) : k;
        if (!cont && k >= 32) begin
            chk("busy_end", busy, 0);
            chk("vec_end", vecOut, 0);
        end else begin
            chk("busy", busy, 1);
            chk("vec", vecOut, kk / C_DWELL);
        end
        chk("sv", sampleValid, (k > 0 && k % C_DWELL == 0));
        chk("done", done, (k > 0 && k % 32 == 0));
        if (k > 0 && k % C_DWELL == 0) begin
            chk("svec", sampleVec, ((k / C_DWELL) - 1) % 8);
            chk("sdata", sampleData, pat_val(p, 3'(((k / C_DWELL) - 1) % 8)));
        end
    endtask

    task automatic do_start(logic [1:0] m, int p);
        pat = p;
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = ~m;
    endtask

    task automatic run_single(logic [1:0] m, int p, logic [15:0] exp_sig);
        int nsv = 0;
        do_start(m, p);
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) tick();
            chk_flow(k, p, 1'b0);
            if (sampleValid) nsv++;
        end
        chk("sig_single", sigOut, exp_sig);
        chk("nsamples", nsv, 8);
        tick();
        chk("idle_after", busy, 0);
        chk("no_done_after", done, 0);
    endtask

    task automatic run_cont(int p, logic [15:0] exp_sig);
        do_start(2'b01, p);
        for (int k = 0; k <= 64; k++) begin
            if (k > 0) tick();
            chk_flow(k, p, 1'b1);
            if (k == 32 || k == 64) chk("sig_cont", sigOut, exp_sig);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("cont_abort_busy", busy, 0);
        chk("cont_abort_vec", vecOut, 0);
        chk("cont_abort_done", done, 0);
        chk("cont_abort_sig", sigOut, exp_sig);
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          pat;
        logic [15:0] exp_sig;
    } sweep_t;

    sweep_t tbl[5];

    initial begin
        tbl[0] = '{mode: 2'b00, pat: 0, exp_sig: 16'h0000};
        tbl[1] = '{mode: 2'b00, pat: 1, exp_sig: 16'h00FF};
        tbl[2] = '{mode: 2'b11, pat: 2, exp_sig: 16'h000F};
        tbl[3] = '{mode: 2'b00, pat: 3, exp_sig: 16'h0FFF};
        tbl[4] = '{mode: 2'b01, pat: 2, exp_sig: 16'h000F};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_vec", vecOut, 0);
        chk("rst_sv", sampleValid, 0);
        chk("rst_done", done, 0);
        chk("rst_sig", sigOut, 0);
        rstN = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].mode == 2'b01) run_cont(tbl[i].pat, tbl[i].exp_sig);
            else run_single(tbl[i].mode, tbl[i].pat, tbl[i].exp_sig);
        end

        // Step mode: waits in WAIT_STEP, stray stepReq during a dwell ignored
        do_start(2'b10, 3);
        chk("step_v0", vecOut, 0);
        for (int v = 0; v < 8; v++) begin
            for (int j = 1; j < C_DWELL; j++) begin
                stepReq = (v == 2 && j == 1);
                tick();
                stepReq = 1'b0;
                chk("step_hold", vecOut, v);
                chk("step_sv0", sampleValid, 0);
            end
            tick();
            chk("step_sv", sampleValid, 1);
            chk("step_svec", sampleVec, v);
            chk("step_sdata", sampleData, pat_val(3, 3'(v)));
            chk("step_done", done, (v == 7));
            if (v == 7) begin
                chk("step_end_busy", busy, 0);
                chk("step_end_vec", vecOut, 0);
            end else begin
                for (int w = 0; w < 5; w++) begin
                    if (w > 0) tick();
                    chk("wait_vec", vecOut, v);
                    chk("wait_busy", busy, 1);
                end
                stepReq = 1'b1;
                tick();
                stepReq = 1'b0;
                chk("step_adv", vecOut, v + 1);
            end
        end
        chk("step_sig", sigOut, 16'h0FFF);

        // Abort at vector 3 with a stray start mid-sweep
        do_start(2'b00, 1);
        for (int k = 1; k <= 12; k++) begin
            start = (k == 5);
            tick();
            start = 1'b0;
            chk("abort_run_vec", vecOut, k / C_DWELL);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_vec", vecOut, 0);
        chk("abort_done", done, 0);
        chk("abort_sig", sigOut, 16'h0FFF);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_prio", busy, 0);

        // Asynchronous reset in the middle of vector 5
        do_start(2'b00, 2);
        for (int k = 1; k <= 20; k++) tick();
        chk("pre_rst_vec", vecOut, 5);
        #2 rstN = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vec", vecOut, 0);
        chk("mid_rst_sig", sigOut, 0);
        chk("mid_rst_svec", sampleVec, 0);
        chk("mid_rst_sdata", sampleData, 0);
        #3 rstN = 1'b1;
        tick();
        run_single(2'b00, 3, 16'h0FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
